// File: rtl/sum_collector_pkg.sv
// Shared types and helpers for the sum_collector row buffer.
// Imported by the top module for its FSM encoding and index sizing.
package sum_collector_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Width of a row index for a row of the given depth.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sum_collector.sv
// Gathers DEPTH consecutive valid sums into a row and drains the row over a
// valid/ready handshake, presenting the running row total alongside it.
module sum_collector
   import sum_collector_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int DEPTH     = 4,
   parameter int TOT_WIDTH = BIT_WIDTH + $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] in_sum,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BIT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic [TOT_WIDTH-1:0] row_total,
   output logic                 overrun
);

   localparam int IW = idx_width(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   state_t               state;
   state_t               state_nxt;
   logic [IW-1:0]        wr_idx;
   logic [IW-1:0]        rd_idx;
   logic [IW-1:0]        rd_nxt;
   logic [TOT_WIDTH-1:0] total;
   logic [BIT_WIDTH-1:0] row_buf [DEPTH];
   logic [BIT_WIDTH-1:0] data_q;
   logic                 last_q;
   logic                 overrun_q;
   logic                 accept;
   logic                 fill_done;
   logic                 handshake;
   logic                 row_done;

   assign accept    = (state == FILL) && in_valid;
   assign fill_done = accept && (wr_idx == LAST_IDX);
   assign handshake = (state == DRAIN) && out_ready;
   assign row_done  = handshake && last_q;
   assign rd_nxt    = rd_idx + IW'(1);

   always_comb begin
      state_nxt = state;
      case (state)
         FILL: begin
            if (fill_done) state_nxt = DRAIN;
            else           state_nxt = FILL;
         end
         DRAIN: begin
            if (row_done) state_nxt = FILL;
            else          state_nxt = DRAIN;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= FILL;
      else        state <= state_nxt;
   end

   // Row storage carries no reset; its contents only matter after a full fill.
   always_ff @(posedge clk) begin
      if (accept) row_buf[wr_idx] <= in_sum;
   end

   // Output element is prefetched so out_data/out_last come straight from flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_idx    <= '0;
         rd_idx    <= '0;
         total     <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (accept) begin
            total  <= total + TOT_WIDTH'(in_sum);
            wr_idx <= fill_done ? '0 : (wr_idx + IW'(1));
         end
         if (fill_done) begin
            data_q <= row_buf[0];
            last_q <= 1'b0;
         end
         if (handshake) begin
            if (last_q) begin
               rd_idx <= '0;
               total  <= '0;
               data_q <= '0;
               last_q <= 1'b0;
            end else begin
               rd_idx <= rd_nxt;
               data_q <= row_buf[rd_nxt];
               last_q <= (rd_nxt == LAST_IDX);
            end
         end
         if (in_valid && (state == DRAIN)) overrun_q <= 1'b1;
      end
   end

   assign in_ready  = (state == FILL);
   assign out_valid = (state == DRAIN);
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign row_total = total;
   assign overrun   = overrun_q;

endmodule

// File: doc/sum_collector.md
Name: sum_collector

Overview:
- Receive end of the registered adder's result interface: consumes the `sum`/`valid` stream and gathers DEPTH consecutive valid sums into one output row.
- Forwards the row downstream over a valid/ready handshake, together with the row total.
- Sits between the adder array and the result write-back in the matrix-multiply datapath.
- Adds buffering and back-pressure that the adder itself lacks.

Parameters:
- BIT_WIDTH, 8, width of each incoming sum and of each outgoing element.
- DEPTH, 4, number of sums per row; must be ≥2.
- TOT_WIDTH, BIT_WIDTH+$clog2(DEPTH), width of the row-total accumulator.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge).
- in_sum  input  BIT_WIDTH  sum from the adder.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block is accepting sums (FILL state).
- out_data  output  BIT_WIDTH  current row element.
- out_valid  output  1  out_data valid.
- out_last  output  1  out_data is the final element of the row.
- out_ready  input  1  downstream accepts out_data.
- row_total  output  TOT_WIDTH  sum of all DEPTH elements of the buffered row; stable throughout DRAIN.
- overrun  output  1  sticky flag: a valid sum arrived while not in FILL.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=FILL, wr_idx=0, rd_idx=0, total=0.
  - Outputs: out_valid=0, out_last=0, out_data=0, row_total=0, overrun=0, in_ready=1 from the next cycle.
  - Buffer contents are don't-care.
  - Reset overrides any in-flight FILL or DRAIN; a partially collected or partially drained row is discarded.
- States: FILL, DRAIN (2-state FSM, registered).
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid: buf[wr_idx]<=in_sum; total<=total+in_sum, zero-extended to TOT_WIDTH, so no overflow is possible; wr_idx++.
  - in_valid==0 cycles (gaps) leave state and indices unchanged.
  - When in_valid and wr_idx==DEPTH-1: wr_idx<=0, state<=DRAIN. row_total already reflects all DEPTH values on entry to DRAIN.
- Latency: the DEPTH-th accepted sum at edge N gives out_valid=1 with out_data=buf[0] in the cycle after edge N.
- DRAIN:
  - in_ready=0, out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==DEPTH-1). All are driven from registered state, no combinational path from out_ready.
  - Handshake on out_valid&&out_ready: rd_idx++. If out_last, then rd_idx<=0, total<=0, state<=FILL.
  - out_ready low holds out_data/out_last/out_valid stable indefinitely.
  - Back-to-back rows: the cycle after the last handshake, in_ready=1 and out_valid=0; there is no bubble beyond that.
- Overrun:
  - in_valid while state==DRAIN sets overrun=1. The sample is dropped; buffer and total are unaffected.
  - overrun clears only on reset.
- row_total:
  - Continuously shows the accumulator.
  - Guaranteed meaningful only while out_valid=1.
  - Reads 0 after the last handshake.
- Simultaneous last handshake and in_valid in the same cycle: state is still DRAIN, so the sample is dropped and overrun is set. Upstream must gate on in_ready.

Decomposition:
- Package sum_collector_pkg holds:
  - state typedef: FILL=1'b0, DRAIN=1'b1.
  - Index-width helper constant: $clog2(DEPTH).
- Single module. The buffer is a small register array inline, so no sub-module is warranted.

Test Plan (BIT_WIDTH=8, DEPTH=4):
- Reset low 2 cycles, then high -> out_valid=0, in_ready=1, overrun=0, row_total=0.
- in_sum 3,5,7,9 on consecutive cycles, out_ready=1 -> out_data 3,5,7,9 on 4 consecutive cycles starting the cycle after 9 is accepted; out_last only with 9; row_total=24; in_ready=1 the cycle after.
- Same row with in_valid gaps (3,-,5,-,-,7,9) -> identical output; out_valid rises exactly one cycle after 9 is accepted.
- 255×4 with out_ready toggling 0/1 each cycle -> each 255 held until handshake; row_total=1020 (10 bits, no wrap); 4 handshakes total.
- in_valid=1 with in_sum=77 during DRAIN -> overrun=1 and stays 1; drained values unchanged; 77 never appears on out_data.
- Reset asserted after 2 of 4 drain handshakes -> next cycle out_valid=0, row_total=0, in_ready=1; new row 1,2,3,4 -> outputs 1,2,3,4, total=10.
